// File: rtl/calendar_ctrl_pkg.sv
// Shared constants for the calendar sequencer.
// Contents: field indices, FSM state codes, the 30-day month mask, the default
//           hour limit and a field one-hot helper.
// Build option: CALENDAR_CTRL_LEAP_EN (used in days_in_month) enables 29-day February.
package clock_pkg;

    localparam logic [2:0] FLD_SEC   = 3'd0;
    localparam logic [2:0] FLD_MIN   = 3'd1;
    localparam logic [2:0] FLD_HOUR  = 3'd2;
    localparam logic [2:0] FLD_DAY   = 3'd3;
    localparam logic [2:0] FLD_MONTH = 3'd4;
    localparam logic [2:0] FLD_YEAR  = 3'd5;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_PULSE      = 3'd1;
    localparam logic [2:0] ST_WAIT       = 3'd2;
    localparam logic [2:0] ST_CLAMP      = 3'd3;
    localparam logic [2:0] ST_CLAMP_WAIT = 3'd4;
    localparam logic [2:0] ST_EDIT       = 3'd5;

    // Bit m set when month m has 30 days (April, June, September, November).
    localparam logic [15:0] DAYS_30_MASK = 16'h0A50;

    localparam logic [4:0] HOUR_MAX_DEFAULT = 5'd23;

    function automatic logic [5:0] field_onehot(input logic [2:0] fld);
        return 6'b000001 << fld;
    endfunction

endpackage

// File: rtl/calendar_ctrl_days_in_month.sv
// days_in_month: number of days in the current month.
// Ports: month (1..12, anything else reads as 31 days), year (0..99), day_num out.
// Build option: CALENDAR_CTRL_LEAP_EN gives February 29 days when year[1:0]==0;
// without it February is always 28 and year is ignored.
module days_in_month
    import clock_pkg::*;
(
    input  logic [3:0] month,
    input  logic [6:0] year,
    output logic [4:0] day_num
);

    // Year bits that do not take part in the leap decision are collected here.
    logic unused_year_s;
    assign unused_year_s = ^year;

    // Month length lookup; out-of-range months fall back to 31.
    always_comb begin
        day_num = 5'd31;
        if (month == 4'd2) begin
`ifdef CALENDAR_CTRL_LEAP_EN
            if (year[1:0] == 2'd0) begin
                day_num = 5'd29;
            end else begin
                day_num = 5'd28;
            end
`else
            day_num = 5'd28;
`endif
        end else if (DAYS_30_MASK[month]) begin
            day_num = 5'd30;
        end else begin
            day_num = 5'd31;
        end
    end

endmodule

// File: rtl/calendar_ctrl.sv
// calendar_ctrl: sequencer for the six-field calendar counter bank
// (sec/min/hour/day/month/year). Turns tick_1hz into one inc pulse per field,
// rippling carries field by field, runs the edit mode and clamps the day field.
// Ports: clk, reset_n (async active low), tick_1hz, btn_mode/btn_up/btn_down,
//        day/month/year and done_inc/done_dec from the counters;
//        cnt_inc/cnt_dec/cnt_en to the counters, day_num, hour_num,
//        edit_field, editing.
// Build option: CALENDAR_CTRL_LEAP_EN (see days_in_month).
module calendar_ctrl
    import clock_pkg::*;
#(
    parameter logic [4:0] HOUR_MAX = HOUR_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [4:0] day,
    input  logic [3:0] month,
    input  logic [6:0] year,
    input  logic [4:0] done_inc,
    input  logic [4:0] done_dec,
    output logic [5:0] cnt_inc,
    output logic [5:0] cnt_dec,
    output logic [5:0] cnt_en,
    output logic [4:0] day_num,
    output logic [4:0] hour_num,
    output logic [2:0] edit_field,
    output logic       editing
);

    logic [2:0] state_r, state_s;
    logic [2:0] k_r, k_s;
    logic [2:0] fld_r, fld_s;
    logic       pend_r, pend_s;
    logic       modep_r, modep_s;
    logic       editing_r, editing_s;
    logic [5:0] inc_r, inc_s;
    logic [5:0] dec_r, dec_s;
    logic [5:0] en_r, en_s;
    logic [4:0] day_num_r;
    logic [4:0] day_num_s;
    logic [5:0] done_ext_s;

    // Decrement wraps never borrow, so done_dec is not consumed.
    logic unused_s;
    assign unused_s = ^done_dec;

    assign done_ext_s = {1'b0, done_inc};

    days_in_month u_dim (
        .month   (month),
        .year    (year),
        .day_num (day_num_s)
    );

    // Next-state, pending flags and next pulse/enable values.
    always_comb begin
        state_s   = state_r;
        k_s       = k_r;
        fld_s     = fld_r;
        editing_s = editing_r;
        modep_s   = modep_r;
        pend_s    = pend_r | (tick_1hz & (state_r != ST_IDLE));
        inc_s     = 6'b000000;
        dec_s     = 6'b000000;
        case (state_r)
            ST_IDLE: begin
                if (tick_1hz | pend_r) begin
                    // A tick wins; a coincident mode press is kept for later.
                    state_s = ST_PULSE;
                    k_s     = FLD_SEC;
                    inc_s   = field_onehot(FLD_SEC);
                    pend_s  = 1'b0;
                    modep_s = modep_r | btn_mode;
                end else if (btn_mode | modep_r) begin
                    state_s   = ST_EDIT;
                    fld_s     = FLD_SEC;
                    editing_s = 1'b1;
                    modep_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // done_inc for field k is visible here, one cycle after its pulse.
                if ((k_r < FLD_YEAR) && done_ext_s[k_r]) begin
                    state_s = ST_PULSE;
                    k_s     = k_r + 3'd1;
                    inc_s   = field_onehot(k_r + 3'd1);
                end else begin
                    state_s = ST_CLAMP;
                end
            end
            ST_CLAMP: begin
                // Compare against the unregistered month length so a month
                // change from the previous cycle is already reflected.
                if (day > day_num_s) begin
                    state_s = ST_CLAMP_WAIT;
                    dec_s   = field_onehot(FLD_DAY);
                end else if (editing_r) begin
                    state_s = ST_EDIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLAMP_WAIT: begin
                state_s = ST_CLAMP;
            end
            ST_EDIT: begin
                if (btn_mode) begin
                    if (fld_r == FLD_YEAR) begin
                        state_s   = ST_IDLE;
                        fld_s     = FLD_SEC;
                        editing_s = 1'b0;
                    end else begin
                        fld_s = fld_r + 3'd1;
                    end
                end else if (btn_up ^ btn_down) begin
                    if (btn_up) begin
                        inc_s = field_onehot(fld_r);
                    end else begin
                        dec_s = field_onehot(fld_r);
                    end
                    // Day, month and year edits can leave the day past month end.
                    if (fld_r >= FLD_DAY) begin
                        state_s = ST_CLAMP_WAIT;
                    end else begin
                        state_s = ST_EDIT;
                    end
                end else begin
                    state_s = ST_EDIT;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                fld_s     = FLD_SEC;
                editing_s = 1'b0;
            end
        endcase
        // While editing only the selected field (plus a clamp on day) may move.
        if (editing_s) begin
            en_s = field_onehot(fld_s) | dec_s;
        end else begin
            en_s = 6'h3F;
        end
    end

    // State, flags and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            k_r       <= 3'd0;
            fld_r     <= 3'd0;
            pend_r    <= 1'b0;
            modep_r   <= 1'b0;
            editing_r <= 1'b0;
            inc_r     <= 6'b000000;
            dec_r     <= 6'b000000;
            en_r      <= 6'b000000;
            day_num_r <= 5'd31;
        end else begin
            state_r   <= state_s;
            k_r       <= k_s;
            fld_r     <= fld_s;
            pend_r    <= pend_s;
            modep_r   <= modep_s;
            editing_r <= editing_s;
            inc_r     <= inc_s;
            dec_r     <= dec_s;
            en_r      <= en_s;
            day_num_r <= day_num_s;
        end
    end

    assign cnt_inc    = inc_r;
    assign cnt_dec    = dec_r;
    assign cnt_en     = en_r;
    assign day_num    = day_num_r;
    assign hour_num   = HOUR_MAX;
    assign edit_field = fld_r;
    assign editing    = editing_r;

endmodule
